// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Contents: FSM state encoding, requester ids and the beats-per-burst helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } state_t;

    localparam logic [1:0] REQ_IC   = 2'd0;   // i_cache line fill
    localparam logic [1:0] REQ_DR   = 2'd1;   // d_cache line fill
    localparam logic [1:0] REQ_DW   = 2'd2;   // d_cache writeback
    localparam logic [1:0] REQ_NONE = 2'd3;   // no owner

    // Number of beats in one burst for a given log2 burst length.
    function automatic int unsigned beats(input int unsigned burst_log2);
        return 32'd1 << burst_log2;
    endfunction

endpackage

// File: rtl/mem_arb_checker.sv
// Protocol checker for the requester side of the memory port arbiter:
// a requester that raised valid must keep it up until its ready pulse.
// Ports: clk, rst_n and each requester's valid/ready pair.
module mem_arb_checker (
    input logic clk,
    input logic rst_n,
    input logic ic_rd_valid,
    input logic ic_rd_ready,
    input logic dc_rd_valid,
    input logic dc_rd_ready,
    input logic dc_wr_valid,
    input logic dc_wr_ready
);

    ic_valid_held: assert property (@(posedge clk) disable iff (!rst_n)
        (ic_rd_valid && !ic_rd_ready) |=> ic_rd_valid);

    dr_valid_held: assert property (@(posedge clk) disable iff (!rst_n)
        (dc_rd_valid && !dc_rd_ready) |=> dc_rd_valid);

    dw_valid_held: assert property (@(posedge clk) disable iff (!rst_n)
        (dc_wr_valid && !dc_wr_ready) |=> dc_wr_valid);

endmodule

// File: rtl/rr_arbiter3.sv
// Combinational 3-way round-robin picker.
// Ports: valid     - request vector {dc_wr, dc_rd, ic_rd}
//        last_grant- id of the previous winner; search starts one past it
//        grant_oh  - one-hot winner (0 when nothing is valid)
//        grant_id  - encoded winner, REQ_NONE when nothing is valid
module rr_arbiter3
    import mem_arb_pkg::*;
(
    input  logic [2:0] valid,
    input  logic [1:0] last_grant,
    output logic [2:0] grant_oh,
    output logic [1:0] grant_id
);

    logic [3:0] valid_ext_s;
    logic [1:0] first_s;
    logic [1:0] second_s;
    logic [1:0] third_s;

    // Search order rotated so the previous winner is tried last.
    always_comb begin
        valid_ext_s = {1'b0, valid};
        first_s     = REQ_IC;
        second_s    = REQ_DR;
        third_s     = REQ_DW;
        case (last_grant)
            2'd0: begin first_s = REQ_DR; second_s = REQ_DW; third_s = REQ_IC; end
            2'd1: begin first_s = REQ_DW; second_s = REQ_IC; third_s = REQ_DR; end
            default: begin first_s = REQ_IC; second_s = REQ_DR; third_s = REQ_DW; end
        endcase
    end

    // First valid requester in the rotated order wins.
    always_comb begin
        grant_id = REQ_NONE;
        grant_oh = 3'b000;
        if (valid_ext_s[first_s]) begin
            grant_id = first_s;
        end else if (valid_ext_s[second_s]) begin
            grant_id = second_s;
        end else if (valid_ext_s[third_s]) begin
            grant_id = third_s;
        end else begin
            grant_id = REQ_NONE;
        end
        case (grant_id)
            REQ_IC:  grant_oh = 3'b001;
            REQ_DR:  grant_oh = 3'b010;
            REQ_DW:  grant_oh = 3'b100;
            default: grant_oh = 3'b000;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates i_cache fill, d_cache fill and d_cache writeback onto one
// external burst memory port, one transaction at a time, round-robin.
// Ports: ic_rd_* / dc_rd_*  fill requests and returned read beats
//        dc_wr_*            writeback request and outgoing write beats
//        mem_*              external memory request / data channels
//        busy, grant_id     transaction status and current owner
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ic_rd_valid,
    input  logic [ADDR_WIDTH-1:0] ic_rd_addr,
    output logic                  ic_rd_ready,
    output logic [DATA_WIDTH-1:0] ic_rd_data,
    output logic                  ic_rd_data_valid,
    input  logic                  dc_rd_valid,
    input  logic [ADDR_WIDTH-1:0] dc_rd_addr,
    output logic                  dc_rd_ready,
    output logic [DATA_WIDTH-1:0] dc_rd_data,
    output logic                  dc_rd_data_valid,
    input  logic                  dc_wr_valid,
    input  logic [ADDR_WIDTH-1:0] dc_wr_addr,
    output logic                  dc_wr_ready,
    input  logic [DATA_WIDTH-1:0] dc_wr_data,
    output logic                  dc_wr_data_ready,
    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_we,
    input  logic                  mem_req_ready,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wdata_valid,
    input  logic                  mem_wdata_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  busy,
    output logic [1:0]            grant_id
);

    localparam int unsigned BEATS = beats(BURST_LOG2);
    localparam logic [BURST_LOG2-1:0] LAST_BEAT = BURST_LOG2'(BEATS - 1);

    state_t                  state_r, state_s;
    logic [BURST_LOG2-1:0]   cnt_r, cnt_s;
    logic [1:0]              last_grant_r, last_grant_s;
    logic [1:0]              owner_r, owner_s;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
    logic                    we_r, we_s;
    logic [2:0]              req_vec_s;
    logic [2:0]              win_oh_s;
    logic [1:0]              win_id_s;

    assign req_vec_s = {dc_wr_valid, dc_rd_valid, ic_rd_valid};

    rr_arbiter3 u_rr (
        .valid      (req_vec_s),
        .last_grant (last_grant_r),
        .grant_oh   (win_oh_s),
        .grant_id   (win_id_s)
    );

    mem_arb_checker u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .ic_rd_valid (ic_rd_valid),
        .ic_rd_ready (ic_rd_ready),
        .dc_rd_valid (dc_rd_valid),
        .dc_rd_ready (dc_rd_ready),
        .dc_wr_valid (dc_wr_valid),
        .dc_wr_ready (dc_wr_ready)
    );

    // State, beat counter and latched transaction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            last_grant_r <= REQ_DW;      // ic_rd wins the first tie
            owner_r      <= REQ_IC;
            addr_r       <= '0;
            we_r         <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            last_grant_r <= last_grant_s;
            owner_r      <= owner_s;
            addr_r       <= addr_s;
            we_r         <= we_s;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_s          = state_r;
        cnt_s            = cnt_r;
        last_grant_s     = last_grant_r;
        owner_s          = owner_r;
        addr_s           = addr_r;
        we_s             = we_r;
        ic_rd_ready      = 1'b0;
        dc_rd_ready      = 1'b0;
        dc_wr_ready      = 1'b0;
        ic_rd_data_valid = 1'b0;
        dc_rd_data_valid = 1'b0;
        dc_wr_data_ready = 1'b0;
        mem_req_valid    = 1'b0;
        mem_wdata_valid  = 1'b0;
        busy             = 1'b1;
        grant_id         = owner_r;
        case (state_r)
            ST_IDLE: begin
                busy     = 1'b0;
                grant_id = REQ_NONE;
                if (|req_vec_s) begin
                    owner_s      = win_id_s;
                    last_grant_s = win_id_s;
                    addr_s       = ({ADDR_WIDTH{win_oh_s[0]}} & ic_rd_addr)
                                 | ({ADDR_WIDTH{win_oh_s[1]}} & dc_rd_addr)
                                 | ({ADDR_WIDTH{win_oh_s[2]}} & dc_wr_addr);
                    we_s         = win_oh_s[2];
                    state_s      = ST_REQ;
                end else begin
                    state_s      = ST_IDLE;
                end
            end
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    case (owner_r)
                        REQ_IC:  ic_rd_ready = 1'b1;
                        REQ_DR:  dc_rd_ready = 1'b1;
                        REQ_DW:  dc_wr_ready = 1'b1;
                        default: ic_rd_ready = 1'b0;
                    endcase
                    cnt_s   = '0;
                    state_s = we_r ? ST_WDATA : ST_RDATA;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WDATA: begin
                mem_wdata_valid  = 1'b1;
                dc_wr_data_ready = mem_wdata_ready;
                if (mem_wdata_ready) begin
                    cnt_s   = cnt_r + 1'b1;
                    state_s = (cnt_r == LAST_BEAT) ? ST_IDLE : ST_WDATA;
                end else begin
                    state_s = ST_WDATA;
                end
            end
            ST_RDATA: begin
                ic_rd_data_valid = mem_rvalid && (owner_r == REQ_IC);
                dc_rd_data_valid = mem_rvalid && (owner_r == REQ_DR);
                if (mem_rvalid) begin
                    cnt_s   = cnt_r + 1'b1;
                    state_s = (cnt_r == LAST_BEAT) ? ST_IDLE : ST_RDATA;
                end else begin
                    state_s = ST_RDATA;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Address/data paths: latched request fields and beat pass-throughs.
    always_comb begin
        mem_req_addr = addr_r;
        mem_req_we   = we_r;
        mem_wdata    = dc_wr_data;
        ic_rd_data   = mem_rdata;
        dc_rd_data   = mem_rdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-level model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

    logic        clk, rst_n;
    logic        ic_rd_valid, ic_rd_ready, ic_rd_data_valid;
    logic [25:0] ic_rd_addr;
    logic [31:0] ic_rd_data;
    logic        dc_rd_valid, dc_rd_ready, dc_rd_data_valid;
    logic [25:0] dc_rd_addr;
    logic [31:0] dc_rd_data;
    logic        dc_wr_valid, dc_wr_ready, dc_wr_data_ready;
    logic [25:0] dc_wr_addr;
    logic [31:0] dc_wr_data;
    logic        mem_req_valid, mem_req_we, mem_req_ready;
    logic [25:0] mem_req_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_wdata_valid, mem_wdata_ready, mem_rvalid;
    logic        busy;
    logic [1:0]  grant_id;

    int n_checks = 0;
    int n_fail   = 0;

    // transaction-level model
    bit          m_act, m_acc, m_we;
    int          m_own, m_last, m_cnt;
    logic [25:0] m_addr;

    // observed events
    logic [31:0] ic_beats[$];
    logic [31:0] dc_beats[$];
    logic [31:0] wr_beats[$];
    int          grant_q[$];
    int          ready_cnt;

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ic_rd_valid(ic_rd_valid), .ic_rd_addr(ic_rd_addr), .ic_rd_ready(ic_rd_ready),
        .ic_rd_data(ic_rd_data), .ic_rd_data_valid(ic_rd_data_valid),
        .dc_rd_valid(dc_rd_valid), .dc_rd_addr(dc_rd_addr), .dc_rd_ready(dc_rd_ready),
        .dc_rd_data(dc_rd_data), .dc_rd_data_valid(dc_rd_data_valid),
        .dc_wr_valid(dc_wr_valid), .dc_wr_addr(dc_wr_addr), .dc_wr_ready(dc_wr_ready),
        .dc_wr_data(dc_wr_data), .dc_wr_data_ready(dc_wr_data_ready),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
        .mem_req_ready(mem_req_ready), .mem_wdata(mem_wdata), .mem_wdata_valid(mem_wdata_valid),
        .mem_wdata_ready(mem_wdata_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .busy(busy), .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        ic_beats.delete(); dc_beats.delete(); wr_beats.delete(); grant_q.delete();
        ready_cnt = 0;
    endtask

    // Compare DUT against the model mid-cycle, log events, then advance the model.
    always @(negedge clk) begin
        logic [2:0] v;
        int c;
        if (!rst_n) begin
            m_act = 1'b0; m_acc = 1'b0; m_we = 1'b0; m_own = 0; m_last = 2; m_cnt = 0; m_addr = '0;
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_grant_id", 32'(grant_id), 32'd3);
            chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
            chk("rst_readies", 32'({ic_rd_ready, dc_rd_ready, dc_wr_ready}), 32'd0);
            chk("rst_data_valids", 32'({ic_rd_data_valid, dc_rd_data_valid, mem_wdata_valid, dc_wr_data_ready}), 32'd0);
        end else begin
            chk("busy", 32'(busy), 32'(m_act));
            chk("grant_id", 32'(grant_id), m_act ? m_own : 3);
            chk("mem_req_valid", 32'(mem_req_valid), 32'(m_act && !m_acc));
            if (m_act && !m_acc) begin
                chk("mem_req_addr", 32'(mem_req_addr), 32'(m_addr));
                chk("mem_req_we", 32'(mem_req_we), 32'(m_we));
            end
            chk("ic_rd_ready", 32'(ic_rd_ready), 32'(m_act && !m_acc && mem_req_ready && m_own == 0));
            chk("dc_rd_ready", 32'(dc_rd_ready), 32'(m_act && !m_acc && mem_req_ready && m_own == 1));
            chk("dc_wr_ready", 32'(dc_wr_ready), 32'(m_act && !m_acc && mem_req_ready && m_own == 2));
            chk("mem_wdata_valid", 32'(mem_wdata_valid), 32'(m_act && m_acc && m_we));
            chk("dc_wr_data_ready", 32'(dc_wr_data_ready), 32'(m_act && m_acc && m_we && mem_wdata_ready));
            chk("ic_rd_data_valid", 32'(ic_rd_data_valid), 32'(m_act && m_acc && !m_we && m_own == 0 && mem_rvalid));
            chk("dc_rd_data_valid", 32'(dc_rd_data_valid), 32'(m_act && m_acc && !m_we && m_own == 1 && mem_rvalid));
            if (m_act && m_acc && m_we) chk("mem_wdata", mem_wdata, dc_wr_data);
            if (m_act && m_acc && !m_we && mem_rvalid) begin
                chk("ic_rd_data", ic_rd_data, mem_rdata);
                chk("dc_rd_data", dc_rd_data, mem_rdata);
            end
            if (ic_rd_data_valid) ic_beats.push_back(ic_rd_data);
            if (dc_rd_data_valid) dc_beats.push_back(dc_rd_data);
            if (dc_wr_data_ready) wr_beats.push_back(mem_wdata);
            if (ic_rd_ready || dc_rd_ready || dc_wr_ready) begin
                ready_cnt++;
                grant_q.push_back(int'(grant_id));
            end
            // advance the model by one clock
            if (!m_act) begin
                v = {dc_wr_valid, dc_rd_valid, ic_rd_valid};
                for (int k = 1; k <= 3; k++) begin
                    c = (m_last + k) % 3;
                    if (v[c] && !m_act) begin
                        m_act = 1'b1; m_acc = 1'b0; m_own = c; m_last = c; m_we = (c == 2);
                        m_addr = (c == 0) ? ic_rd_addr : (c == 1) ? dc_rd_addr : dc_wr_addr;
                    end
                end
            end else if (!m_acc) begin
                if (mem_req_ready) begin m_acc = 1'b1; m_cnt = 0; end
            end else if (m_we ? mem_wdata_ready : mem_rvalid) begin
                m_cnt++;
                if (m_cnt == 4) m_act = 1'b0;
            end
        end
    end

    // Memory responder + requester release until everything is drained.
    task automatic serve(input logic [31:0] base, input int max_cyc);
        int beat = 0;
        bit done = 1'b0;
        bit d_ic, d_dr, d_dw;
        for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
            mem_req_ready   = (cyc % 3 != 1);
            mem_rvalid      = (cyc % 4 != 3);
            mem_rdata       = base + 32'(beat);
            mem_wdata_ready = (cyc % 2 == 0);
            #1;
            d_ic = ic_rd_ready; d_dr = dc_rd_ready; d_dw = dc_wr_ready;
            if (ic_rd_data_valid || dc_rd_data_valid) beat++;
            tick();
            if (d_ic) ic_rd_valid = 1'b0;
            if (d_dr) dc_rd_valid = 1'b0;
            if (d_dw) dc_wr_valid = 1'b0;
            if (!busy && !ic_rd_valid && !dc_rd_valid && !dc_wr_valid) done = 1'b1;
        end
        mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_wdata_ready = 1'b0;
        chk("serve_done", 32'(done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n = 1'b0;
        ic_rd_valid = 1'b0; ic_rd_addr = '0; dc_rd_valid = 1'b0; dc_rd_addr = '0;
        dc_wr_valid = 1'b0; dc_wr_addr = '0; dc_wr_data = '0;
        mem_req_ready = 1'b0; mem_wdata_ready = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
        ready_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("lit_reset_busy", 32'(busy), 32'd0);
        chk("lit_reset_grant", 32'(grant_id), 32'd3);
        rst_n = 1'b1;

        // single ic read
        clear_logs();
        ic_rd_valid = 1'b1; ic_rd_addr = 26'h0000100;
        tick();
        chk("lit_t1_req_valid", 32'(mem_req_valid), 32'd1);
        chk("lit_t1_req_addr", 32'(mem_req_addr), 32'h100);
        chk("lit_t1_req_we", 32'(mem_req_we), 32'd0);
        mem_req_ready = 1'b1;
        #1;
        chk("lit_t1_ic_ready", 32'(ic_rd_ready), 32'd1);
        tick();
        ic_rd_valid = 1'b0; mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1; mem_rdata = 32'hA0 + 32'(i);
            tick();
        end
        mem_rvalid = 1'b0;
        chk("lit_t1_idle", 32'(busy), 32'd0);
        chk("lit_t1_beats", 32'(ic_beats.size()), 32'd4);
        for (int i = 0; i < 4 && i < ic_beats.size(); i++) chk("lit_t1_beat", ic_beats[i], 32'hA0 + 32'(i));
        chk("lit_t1_dc_beats", 32'(dc_beats.size()), 32'd0);
        chk("lit_t1_ready_cnt", 32'(ready_cnt), 32'd1);

        // all three valid from reset: round-robin 0,1,2 then 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clear_logs();
        ic_rd_valid = 1'b1; ic_rd_addr = 26'h10;
        dc_rd_valid = 1'b1; dc_rd_addr = 26'h20;
        dc_wr_valid = 1'b1; dc_wr_addr = 26'h30; dc_wr_data = 32'hDEAD0000;
        serve(32'hC0, 200);
        ic_rd_valid = 1'b1; ic_rd_addr = 26'h40;
        serve(32'hC8, 100);
        chk("lit_t2_grants", 32'(grant_q.size()), 32'd4);
        if (grant_q.size() == 4) begin
            chk("lit_t2_g0", 32'(grant_q[0]), 32'd0);
            chk("lit_t2_g1", 32'(grant_q[1]), 32'd1);
            chk("lit_t2_g2", 32'(grant_q[2]), 32'd2);
            chk("lit_t2_g3", 32'(grant_q[3]), 32'd0);
        end

        // writeback with mem_wdata_ready toggling 1,0
        clear_logs();
        dc_wr_valid = 1'b1; dc_wr_addr = 26'h200;
        tick();
        mem_req_ready = 1'b1;
        #1;
        chk("lit_t3_wr_ready", 32'(dc_wr_ready), 32'd1);
        chk("lit_t3_we", 32'(mem_req_we), 32'd1);
        tick();
        mem_req_ready = 1'b0; dc_wr_valid = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            mem_wdata_ready = (cyc % 2 == 0);
            dc_wr_data = 32'h11110000 + 32'(k);
            #1;
            if (cyc == 7) chk("lit_t3_idle_after_last", 32'(busy), 32'd0);
            if (dc_wr_data_ready) k++;
            tick();
        end
        mem_wdata_ready = 1'b0;
        chk("lit_t3_wr_count", 32'(wr_beats.size()), 32'd4);
        for (int i = 0; i < 4 && i < wr_beats.size(); i++) chk("lit_t3_wbeat", wr_beats[i], 32'h11110000 + 32'(i));

        // memory stalls the request for 10 cycles
        clear_logs();
        dc_rd_valid = 1'b1; dc_rd_addr = 26'h3F0;
        tick();
        for (int i = 0; i < 10; i++) begin
            mem_req_ready = 1'b0;
            #1;
            chk("lit_t4_req_valid", 32'(mem_req_valid), 32'd1);
            chk("lit_t4_req_addr", 32'(mem_req_addr), 32'h3F0);
            tick();
        end
        chk("lit_t4_no_ready", 32'(ready_cnt), 32'd0);
        serve(32'hD0, 100);
        chk("lit_t4_beats", 32'(dc_beats.size()), 32'd4);
        for (int i = 0; i < 4 && i < dc_beats.size(); i++) chk("lit_t4_beat", dc_beats[i], 32'hD0 + 32'(i));

        // reset during beat 2 of a read
        clear_logs();
        ic_rd_valid = 1'b1; ic_rd_addr = 26'h40;
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0; ic_rd_valid = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hB0;
        tick();
        mem_rdata = 32'hB1;
        tick();
        mem_rdata = 32'hB2;
        rst_n = 1'b0;
        #1;
        chk("lit_t5_busy", 32'(busy), 32'd0);
        chk("lit_t5_grant", 32'(grant_id), 32'd3);
        chk("lit_t5_no_valid", 32'(ic_rd_data_valid), 32'd0);
        chk("lit_t5_beats_before", 32'(ic_beats.size()), 32'd2);
        tick();
        rst_n = 1'b1; mem_rvalid = 1'b0;
        clear_logs();
        dc_rd_valid = 1'b1; dc_rd_addr = 26'h80;
        serve(32'hE0, 100);
        chk("lit_t5_dc_beats", 32'(dc_beats.size()), 32'd4);
        for (int i = 0; i < 4 && i < dc_beats.size(); i++) chk("lit_t5_beat", dc_beats[i], 32'hE0 + 32'(i));
        chk("lit_t5_ic_beats", 32'(ic_beats.size()), 32'd0);

        // spurious mem_rvalid while idle
        mem_rvalid = 1'b1; mem_rdata = 32'h5A5A5A5A;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lit_t6_ic_dv", 32'(ic_rd_data_valid), 32'd0);
            chk("lit_t6_dc_dv", 32'(dc_rd_data_valid), 32'd0);
            tick();
        end
        mem_rvalid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
